// File: rtl/pmon_i2c_target_if.sv
// Power-monitor I2C bus as seen by the target: bus clock and pad data in,
// open-drain pull-down enable out.
`timescale 1ns/1ps

interface pmon_i2c_target_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/pmon_i2c_target.sv
// I2C target emulating the shunt power-monitor register map.
// Measurement registers are served from parallel inputs, setting registers
// are held locally. All bus sampling runs on clk_50 after synchronisation.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | bus free or never addressed
// ADDR      | shifting address byte after START
// ADDR_ACK  | address matched, driving ACK
// IGNORE    | address mismatch, silent until START/STOP
// PTR       | shifting pointer byte
// PTR_ACK   | driving ACK for pointer, pointer loaded
// WR_HI     | shifting write data MSB
// WR_ACK1   | driving ACK for MSB
// WR_LO     | shifting write data LSB
// WR_ACK2   | driving ACK for LSB, write commits on its SCL rise
// RD_HI     | driving snapshot [15:8]
// RD_MACK1  | released, sampling initiator ACK/NACK
// RD_LO     | driving snapshot [7:0]
// RD_MACK2  | released, sampling initiator ACK/NACK
// WAIT_STOP | initiator NACKed, released until START/STOP
`timescale 1ns/1ps

module pmon_i2c_target #(
    parameter logic [6:0]  DEV_ADDR   = 7'h40,
    parameter logic [15:0] DIE_ID_VAL = 16'h2260,
    parameter logic [15:0] CFG_RST    = 16'h4127
) (
    input  logic                    clk_50,
    input  logic                    reset_n,
    pmon_i2c_target_if.slave        i2c,
    input  logic [15:0]             shunt_v,
    input  logic [15:0]             bus_v,
    input  logic [15:0]             power,
    input  logic [15:0]             current,
    output logic [15:0]             configuration,
    output logic [15:0]             calibration,
    output logic [15:0]             mask_enable,
    output logic [15:0]             alert_limit,
    output logic                    wr_strobe,
    output logic [7:0]              wr_ptr,
    output logic                    busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, IGNORE, PTR, PTR_ACK, WR_HI, WR_ACK1,
        WR_LO, WR_ACK2, RD_HI, RD_MACK1, RD_LO, RD_MACK2, WAIT_STOP
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_d, sda_d;
    logic        scl, sda, scl_rise, scl_fall, start_cond, stop_cond;
    logic [3:0]  cnt, cnt_nxt;
    logic        sda_oe_r, oe_nxt, busy_nxt;
    logic [7:0]  shift, ptr, wr_hi;
    logic [15:0] snap, rd_word;
    logic        nack;
    logic        shift_en, load_ptr, load_hi, commit, snap_load, ack_en;
    logic        ptr_rw;

    // Two-flop synchronisers plus history flop; the idle bus is high.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], i2c.scl_in};
            sda_sync <= {sda_sync[0], i2c.sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl        = scl_sync[1];
    assign sda        = sda_sync[1];
    assign scl_rise   = scl & ~scl_d;
    assign scl_fall   = ~scl & scl_d;
    // SDA may only move while SCL is held high to form START/STOP.
    assign start_cond = scl & scl_d & ~sda & sda_d;
    assign stop_cond  = scl & scl_d & sda & ~sda_d;

    assign ptr_rw = (ptr == 8'h00) || (ptr == 8'h05) || (ptr == 8'h06) || (ptr == 8'h07);

    // Read mux by pointer; unmapped pointers read zero.
    always_comb begin
        rd_word = 16'h0000;
        case (ptr)
            8'h00:   rd_word = configuration;
            8'h01:   rd_word = shunt_v;
            8'h02:   rd_word = bus_v;
            8'h03:   rd_word = power;
            8'h04:   rd_word = current;
            8'h05:   rd_word = calibration;
            8'h06:   rd_word = mask_enable;
            8'h07:   rd_word = alert_limit;
            8'hFF:   rd_word = DIE_ID_VAL;
            default: rd_word = 16'h0000;
        endcase
    end

    // FSM state, bit counter, pad drive and busy flag.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            sda_oe_r <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sda_oe_r <= oe_nxt;
            busy     <= busy_nxt;
        end
    end

    // Next state and datapath controls; pad drive only moves on SCL fall
    // so the initiator always sees stable data while SCL is high.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        oe_nxt    = sda_oe_r;
        busy_nxt  = busy;
        shift_en  = 1'b0;
        load_ptr  = 1'b0;
        load_hi   = 1'b0;
        commit    = 1'b0;
        snap_load = 1'b0;
        ack_en    = 1'b0;
        if (stop_cond) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
        end else if (start_cond) begin
            state_nxt = ADDR;
            cnt_nxt   = 4'd0;
            oe_nxt    = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WR_HI, WR_LO: begin
                    if (scl_rise) begin
                        shift_en = 1'b1;
                        cnt_nxt  = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        oe_nxt = 1'b1;
                        case (state)
                            ADDR: begin
                                if (shift[7:1] == DEV_ADDR) begin
                                    state_nxt = ADDR_ACK;
                                    busy_nxt  = 1'b1;
                                end else begin
                                    state_nxt = IGNORE;
                                    oe_nxt    = 1'b0;
                                    busy_nxt  = 1'b0;
                                end
                            end
                            PTR: begin
                                state_nxt = PTR_ACK;
                                load_ptr  = 1'b1;
                            end
                            WR_HI: begin
                                state_nxt = WR_ACK1;
                                load_hi   = 1'b1;
                            end
                            default: state_nxt = WR_ACK2;
                        endcase
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_nxt = 4'd0;
                        if (shift[0]) begin
                            state_nxt = RD_HI;
                            snap_load = 1'b1;
                            oe_nxt    = ~rd_word[15];
                        end else begin
                            state_nxt = PTR;
                            oe_nxt    = 1'b0;
                        end
                    end
                end
                PTR_ACK, WR_ACK1, WR_ACK2: begin
                    if (scl_rise && state == WR_ACK2) begin
                        commit = 1'b1;
                    end else if (scl_fall) begin
                        state_nxt = (state == WR_ACK1) ? WR_LO : WR_HI;
                        cnt_nxt   = 4'd0;
                        oe_nxt    = 1'b0;
                    end
                end
                RD_HI, RD_LO: begin
                    if (scl_rise) begin
                        cnt_nxt = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            state_nxt = (state == RD_HI) ? RD_MACK1 : RD_MACK2;
                            oe_nxt    = 1'b0;
                        end else if (state == RD_HI) begin
                            oe_nxt = ~snap[4'(4'd15 - cnt)];
                        end else begin
                            oe_nxt = ~snap[4'(4'd7 - cnt)];
                        end
                    end
                end
                RD_MACK1, RD_MACK2: begin
                    if (scl_rise) begin
                        ack_en = 1'b1;
                    end else if (scl_fall) begin
                        cnt_nxt = 4'd0;
                        if (nack) begin
                            state_nxt = WAIT_STOP;
                            oe_nxt    = 1'b0;
                        end else if (state == RD_MACK1) begin
                            state_nxt = RD_LO;
                            oe_nxt    = ~snap[7];
                        end else begin
                            state_nxt = RD_HI;
                            snap_load = 1'b1;
                            oe_nxt    = ~rd_word[15];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Shift register, pointer, read snapshot and writable register file.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            shift         <= 8'h00;
            ptr           <= 8'h00;
            wr_hi         <= 8'h00;
            snap          <= 16'h0000;
            nack          <= 1'b0;
            configuration <= CFG_RST;
            calibration   <= 16'h0000;
            mask_enable   <= 16'h0000;
            alert_limit   <= 16'h0000;
            wr_strobe     <= 1'b0;
            wr_ptr        <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            if (shift_en)  shift <= {shift[6:0], sda};
            if (load_ptr)  ptr   <= shift;
            if (load_hi)   wr_hi <= shift;
            if (ack_en)    nack  <= sda;
            if (snap_load) snap  <= rd_word;
            if (commit && ptr_rw) begin
                wr_strobe <= 1'b1;
                wr_ptr    <= ptr;
                case (ptr)
                    8'h00:   configuration <= {wr_hi, shift};
                    8'h05:   calibration   <= {wr_hi, shift};
                    8'h06:   mask_enable   <= {wr_hi, shift};
                    8'h07:   alert_limit   <= {wr_hi, shift};
                    default: ;
                endcase
            end
        end
    end

    assign i2c.sda_oe = sda_oe_r;

endmodule
